// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multicycle RISC-V control unit:
// opcodes, ALU operation codes and the FSM state encoding.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WR,
        S_WB_ALU,
        S_WB_MEM,
        S_BRANCH
    } state_e;

    // States that issue a memory request and wait for completion
    function automatic logic is_mem_wait(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory and flags when the
// wait limit has been reached. Saturates at the limit.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expired = (cnt_q == LIMIT);

    // Clear wins over counting; never count past the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch, decode,
// execute, memory and write-back with a memory wait timeout.
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic       alusrc,
    output logic [1:0] alu_op,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_req,
    output logic       mem_we,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       o_illegal,
    output logic       o_fault
);

    state_e     state_q;
    state_e     state_d;
    logic [6:0] opcode_q;
    logic       expired;
    logic       tmr_clear;
    logic       tmr_enable;

    // Restart the count on any state change, a fault, or
    // whenever we are not in a memory wait state
    assign tmr_clear  = (state_d != state_q) || o_fault
                     || !is_mem_wait(state_q);
    assign tmr_enable = is_mem_wait(state_q) && !i_mem_ready;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .expired (expired)
    );

    // State and latched opcode registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_q <= i_opcode;
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        alusrc     = 1'b0;
        alu_op     = ALU_ADD;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        o_illegal  = 1'b0;
        o_fault    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (i_mem_ready) begin
                    mem_req  = 1'b1;
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (expired) begin
                    o_fault = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    mem_req = 1'b1;
                end
            end
            S_DECODE: begin
                case (i_opcode)
                    OP_R:      state_d = S_EXEC_R;
                    OP_I:      state_d = S_EXEC_I;
                    OP_LOAD:   state_d = S_MEM_ADDR;
                    OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH: state_d = S_BRANCH;
                    default: begin
                        o_illegal = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_op  = ALU_FUNCT;
                state_d = S_WB_ALU;
            end
            S_EXEC_I: begin
                alusrc  = 1'b1;
                alu_op  = ALU_FUNCT;
                state_d = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                alusrc  = 1'b1;
                state_d = (opcode_q == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                if (i_mem_ready) begin
                    mem_req = 1'b1;
                    state_d = S_WB_MEM;
                end else if (expired) begin
                    o_fault = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    mem_req = 1'b1;
                end
            end
            S_MEM_WR: begin
                if (i_mem_ready) begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    state_d = S_FETCH;
                end else if (expired) begin
                    o_fault = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                end
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_op   = ALU_SUB;
                pc_write = i_zero;
                state_d  = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed per-cycle
// vectors queue expected outputs, a monitor compares each cycle.
module tb_multicycle_controller;

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] ST = 7'b0100011;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    // {alusrc, alu_op, pc_write, ir_write, mem_req, mem_we,
    //  reg_write, mem_to_reg, o_illegal, o_fault}
    localparam logic [10:0] E_FWAIT = 11'b0_00_0_0_1_0_0_0_0_0;
    localparam logic [10:0] E_FRDY  = 11'b0_00_1_1_1_0_0_0_0_0;
    localparam logic [10:0] E_DEC   = 11'b0_00_0_0_0_0_0_0_0_0;
    localparam logic [10:0] E_ILL   = 11'b0_00_0_0_0_0_0_0_1_0;
    localparam logic [10:0] E_EXR   = 11'b0_10_0_0_0_0_0_0_0_0;
    localparam logic [10:0] E_EXI   = 11'b1_10_0_0_0_0_0_0_0_0;
    localparam logic [10:0] E_MADDR = 11'b1_00_0_0_0_0_0_0_0_0;
    localparam logic [10:0] E_MRD   = 11'b0_00_0_0_1_0_0_0_0_0;
    localparam logic [10:0] E_MWR   = 11'b0_00_0_0_1_1_0_0_0_0;
    localparam logic [10:0] E_WBA   = 11'b0_00_0_0_0_0_1_0_0_0;
    localparam logic [10:0] E_WBM   = 11'b0_00_0_0_0_0_1_1_0_0;
    localparam logic [10:0] E_BRT   = 11'b0_01_1_0_0_0_0_0_0_0;
    localparam logic [10:0] E_BRN   = 11'b0_01_0_0_0_0_0_0_0_0;
    localparam logic [10:0] E_FAULT = 11'b0_00_0_0_0_0_0_0_0_1;

    logic       clk;
    logic       rst;
    logic [6:0] i_opcode;
    logic       i_zero;
    logic       i_mem_ready;
    logic       alusrc;
    logic [1:0] alu_op;
    logic       pc_write;
    logic       ir_write;
    logic       mem_req;
    logic       mem_we;
    logic       reg_write;
    logic       mem_to_reg;
    logic       o_illegal;
    logic       o_fault;

    typedef struct {
        string       name;
        logic [10:0] exp;
    } vec_t;

    vec_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    multicycle_controller #(
        .TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_opcode    (i_opcode),
        .i_zero      (i_zero),
        .i_mem_ready (i_mem_ready),
        .alusrc      (alusrc),
        .alu_op      (alu_op),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .o_illegal   (o_illegal),
        .o_fault     (o_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare outputs mid-cycle against queued expectations
    initial begin
        vec_t        v;
        logic [10:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                v   = sb_q.pop_front();
                act = {alusrc, alu_op, pc_write, ir_write, mem_req,
                       mem_we, reg_write, mem_to_reg, o_illegal, o_fault};
                n_vec++;
                if (act !== v.exp) begin
                    n_err++;
                    $display("FAIL %s: got %b expected %b",
                             v.name, act, v.exp);
                end
            end
        end
    end

    task automatic step(input string nm, input logic [6:0] op,
                        input logic rdy, input logic z,
                        input logic [10:0] e);
        vec_t v;
        i_opcode    = op;
        i_mem_ready = rdy;
        i_zero      = z;
        v.name      = nm;
        v.exp       = e;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        i_opcode    = '0;
        i_zero      = 1'b0;
        i_mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        step("reset_fetch", R, 1'b0, 1'b0, E_FWAIT);

        // R-type, FETCH->FETCH in 4 cycles
        step("r_fetch", R, 1'b1, 1'b0, E_FRDY);
        step("r_decode", R, 1'b1, 1'b0, E_DEC);
        step("r_exec", R, 1'b1, 1'b0, E_EXR);
        step("r_wb", R, 1'b0, 1'b0, E_WBA);

        // I-type
        step("i_fetch", I, 1'b1, 1'b0, E_FRDY);
        step("i_decode", I, 1'b0, 1'b0, E_DEC);
        step("i_exec", I, 1'b0, 1'b0, E_EXI);
        step("i_wb", I, 1'b0, 1'b0, E_WBA);

        // Load, ready ignored in DECODE/MEM_ADDR, then 3-cycle delay
        step("ld_fetch", LD, 1'b1, 1'b0, E_FRDY);
        step("ld_decode", LD, 1'b1, 1'b0, E_DEC);
        step("ld_addr", LD, 1'b1, 1'b0, E_MADDR);
        step("ld_rd_w0", LD, 1'b0, 1'b0, E_MRD);
        step("ld_rd_w1", LD, 1'b0, 1'b0, E_MRD);
        step("ld_rd_w2", LD, 1'b0, 1'b0, E_MRD);
        step("ld_rd_done", LD, 1'b1, 1'b0, E_MRD);
        step("ld_wb", LD, 1'b0, 1'b0, E_WBM);

        // Branch taken then not taken
        step("beq_t_fetch", BR, 1'b1, 1'b1, E_FRDY);
        step("beq_t_decode", BR, 1'b0, 1'b1, E_DEC);
        step("beq_t_branch", BR, 1'b0, 1'b1, E_BRT);
        step("beq_n_fetch", BR, 1'b1, 1'b0, E_FRDY);
        step("beq_n_decode", BR, 1'b0, 1'b0, E_DEC);
        step("beq_n_branch", BR, 1'b0, 1'b0, E_BRN);

        // Illegal opcode
        step("ill_fetch", BAD, 1'b1, 1'b0, E_FRDY);
        step("ill_decode", BAD, 1'b0, 1'b0, E_ILL);

        // Store with immediate ready
        step("st_fetch", ST, 1'b1, 1'b0, E_FRDY);
        step("st_decode", ST, 1'b0, 1'b0, E_DEC);
        step("st_addr", ST, 1'b0, 1'b0, E_MADDR);
        step("st_wr", ST, 1'b1, 1'b0, E_MWR);

        // Ready arrives exactly at the limit: completion, no fault
        for (int k = 0; k < 16; k++) begin
            step("lim_fetch_wait", ST, 1'b0, 1'b0, E_FWAIT);
        end
        step("lim_fetch_rdy", ST, 1'b1, 1'b0, E_FRDY);
        step("st2_decode", ST, 1'b0, 1'b0, E_DEC);
        step("st2_addr", ST, 1'b0, 1'b0, E_MADDR);
        step("st2_wr_w0", ST, 1'b0, 1'b0, E_MWR);
        step("st2_wr_w1", ST, 1'b0, 1'b0, E_MWR);
        step("st2_wr_w2", ST, 1'b0, 1'b0, E_MWR);

        // Reset during the store wait aborts it
        rst = 1'b1;
        step("st2_wr_at_rst", ST, 1'b0, 1'b0, E_MWR);
        rst = 1'b0;

        // Counter restarted at 0: fault after exactly 16 waits, twice
        for (int k = 0; k < 16; k++) begin
            step("post_rst_fetch_wait", R, 1'b0, 1'b0, E_FWAIT);
        end
        step("fetch_fault", R, 1'b0, 1'b0, E_FAULT);
        for (int k = 0; k < 16; k++) begin
            step("refetch_wait", R, 1'b0, 1'b0, E_FWAIT);
        end
        step("fetch_fault2", R, 1'b0, 1'b0, E_FAULT);

        // Timeout in MEM_RD
        step("ldto_fetch", LD, 1'b1, 1'b0, E_FRDY);
        step("ldto_decode", LD, 1'b0, 1'b0, E_DEC);
        step("ldto_addr", LD, 1'b0, 1'b0, E_MADDR);
        for (int k = 0; k < 16; k++) begin
            step("ldto_rd_wait", LD, 1'b0, 1'b0, E_MRD);
        end
        step("ldto_fault", LD, 1'b0, 1'b0, E_FAULT);

        // Normal operation resumes
        step("rec_fetch", R, 1'b1, 1'b0, E_FRDY);
        step("rec_decode", R, 1'b0, 1'b0, E_DEC);
        step("rec_exec", R, 1'b0, 1'b0, E_EXR);
        step("rec_wb", R, 1'b0, 1'b0, E_WBA);

        repeat (2) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0",
                     sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum cycles a memory phase waits for i_mem_ready before faulting.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_opcode  input  7  opcode field of the instruction register, sampled in DECODE.
REQ-005 SHALL have port i_zero  input  1  ALU zero flag, sampled in BRANCH.
REQ-006 SHALL have port i_mem_ready  input  1  memory completion strobe for the current request.
REQ-007 SHALL have port alusrc  output  1  ALU operand-B select: 0 = register file, 1 = immediate.
REQ-008 SHALL have port alu_op  output  2  00 add, 01 subtract, 10 funct-decoded.
REQ-009 SHALL have outputs pc_write, ir_write, mem_req, mem_we, reg_write, mem_to_reg  output  1 each  datapath enables.
REQ-010 SHALL have outputs o_illegal, o_fault  output  1 each  single-cycle error pulses.

Function
REQ-011 SHALL implement a Moore FSM with states FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH; outputs decode from state only (except pc_write and ir_write in FETCH, and pc_write in BRANCH).
REQ-012 FETCH: mem_req=1; on i_mem_ready: ir_write=1, pc_write=1 (PC+4), next DECODE; otherwise hold FETCH.
REQ-013 DECODE: one cycle; opcode 0110011 -> EXEC_R, 0010011 -> EXEC_I, 0000011 or 0100011 -> MEM_ADDR, 1100011 -> BRANCH; any other -> o_illegal=1 for that cycle, next FETCH.
REQ-014 EXEC_R: alusrc=0, alu_op=10, next WB_ALU.
REQ-015 EXEC_I: alusrc=1, alu_op=10, next WB_ALU.
REQ-016 MEM_ADDR: alusrc=1, alu_op=00; next MEM_RD for load, MEM_WR for store (opcode latched in DECODE).
REQ-017 MEM_RD: mem_req=1, mem_we=0; on i_mem_ready next WB_MEM. MEM_WR: mem_req=1, mem_we=1; on i_mem_ready next FETCH.
REQ-018 WB_ALU: reg_write=1, mem_to_reg=0. WB_MEM: reg_write=1, mem_to_reg=1. Both next FETCH.
REQ-019 BRANCH: alusrc=0, alu_op=01; pc_write=1 iff i_zero=1; next FETCH.
REQ-020 In all states not listed as driving them, alusrc=0, alu_op=00 and every enable/pulse SHALL be 0.
REQ-021 Wait counter SHALL clear on entry to FETCH, MEM_RD, MEM_WR and count each cycle i_mem_ready=0 there; on reaching TIMEOUT: o_fault=1 for one cycle, mem_req drops, next FETCH (counter cleared).
REQ-022 i_mem_ready arriving on the same cycle the count reaches TIMEOUT SHALL be honoured as completion; no fault.
REQ-023 i_mem_ready outside FETCH/MEM_RD/MEM_WR SHALL be ignored.
REQ-024 Latency with immediate i_mem_ready: R/I-type 4 cycles, branch 3, store 4, load 5, FETCH to FETCH.
REQ-025 Counter width SHALL be clog2(TIMEOUT+1); no wrap-around permitted.

Reset
REQ-026 While rst=1 at a clock edge: state <= FETCH, wait counter <= 0, latched opcode <= 0; all outputs are combinational from this reset state (mem_req=1, others 0) from the following cycle.
REQ-027 rst asserted in any state, including mid-memory wait, SHALL abort the operation with no write-enable asserted in the cycle after the edge.

Structure
REQ-028 Opcode constants, state encoding and alu_op codes SHALL live in shared package rv_ctrl_pkg.
REQ-029 Wait counter with timeout compare SHALL be sub-module mem_wait_timer (ports clk, rst, clear, enable, expired).

Verification
REQ-030 R-type (0110011), i_mem_ready=1 in FETCH -> FETCH,DECODE,EXEC_R(alusrc=0,alu_op=10),WB_ALU(reg_write=1), back to FETCH at cycle 4.
REQ-031 Load (0000011), i_mem_ready delayed 3 cycles in MEM_RD -> MEM_RD held 4 cycles, then WB_MEM with reg_write=1, mem_to_reg=1.
REQ-032 BEQ (1100011) with i_zero=1 then i_zero=0 -> pc_write=1 in BRANCH first case, 0 second case; alu_op=01 both.
REQ-033 i_mem_ready held 0 in FETCH, TIMEOUT=16 -> o_fault pulses after 16 waiting cycles, FETCH re-entered with counter 0; ready on cycle 16 -> no fault.
REQ-034 Opcode 1111111 -> o_illegal=1 for one cycle in DECODE, no reg_write/mem_req in DECODE, next FETCH.
REQ-035 rst=1 during MEM_WR wait -> next cycle state FETCH, mem_we=0, counter 0.
